multdiv_issue_ctrl: RTL
=======================

Name: multdiv_issue_ctrl

Overview:
- Sequences the shared multi-cycle multiply/divide unit from the execute stage of the five-stage pipeline.
- Accepts a mul/div op, latches its operands and destination, and pulses a start strobe to the unit.
- Holds the front of the pipeline stalled until the unit finishes or times out.
- Then issues one writeback request: either the result to rd, or an exception code to $r30 (rstatus).

Parameters:
TIMEOUT_CYCLES, 40, max BUSY cycles before forced abort; legal range 2..255
MULT_EXC_CODE, 4, value written to rstatus on mult overflow or timeout
DIV_EXC_CODE, 5, value written to rstatus on divide-by-zero or timeout
STATUS_REG, 30, register index receiving exception codes

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state
ex_valid  in  1  execute-stage instruction valid
ex_is_mult  in  1  execute op is mul
ex_is_div  in  1  execute op is div; never high with ex_is_mult
ex_rd  in  5  destination register
ex_a  in  32  operand A
ex_b  in  32  operand B
md_ready  in  1  unit result valid (single-cycle pulse)
md_exception  in  1  unit exception, valid with md_ready
md_result  in  32  unit result, valid with md_ready
md_start_mult  out  1  one-cycle start strobe, multiply
md_start_div  out  1  one-cycle start strobe, divide
md_a  out  32  latched operand A
md_b  out  32  latched operand B
stall  out  1  freeze PC, F/D and D/X latches; bubble into X/M
busy  out  1  controller not IDLE
wb_valid  out  1  writeback request, one cycle
wb_rd  out  5  writeback register
wb_data  out  32  writeback value

Behaviour:
- Reset (reset=0, async): state IDLE; every output 0; cycle counter 0; latched op, rd and operands 0.
- States: IDLE, BUSY, DONE.
- IDLE, accept condition: ex_valid & (ex_is_mult | ex_is_div).
  - stall=1 combinationally in the accept cycle.
  - At the edge: latch ex_a, ex_b, ex_rd and op type; counter←0; go to BUSY.
- BUSY:
  - stall=1, busy=1.
  - md_start_mult or md_start_div is high for the first BUSY cycle only, per the latched op. It is a registered strobe.
  - md_a and md_b stay stable for the whole op.
  - Counter increments each BUSY cycle.
  - md_ready=1: capture md_result and md_exception; go to DONE.
  - md_ready=0 with counter==TIMEOUT_CYCLES-1: set exception flag; go to DONE.
  - md_ready in the first BUSY cycle (same cycle as the strobe) is honored.
- DONE (exactly one cycle): stall=0, busy=1, wb_valid=1.
  - Exception: wb_rd=STATUS_REG; wb_data=MULT_EXC_CODE or DIV_EXC_CODE per op.
  - No exception: wb_rd=latched rd, wb_data=captured result.
  - No exception and rd==0: wb_valid=0, so $r0 is never written.
  - Next state is IDLE.
- Latency from accept to wb_valid = (BUSY cycles)+1. The pipeline advances during DONE.
- Back-to-back ops: a new op reaches execute in the cycle after DONE and is accepted in IDLE. No lost or duplicated strobe.
- md_ready while in IDLE or DONE: ignored.
- Reset mid-op: immediate return to IDLE with all outputs 0. No writeback and no strobe is emitted for the aborted op.
- All wb_* and md_start_* outputs are registered. stall is combinational from state and ex inputs.

Test Plan:
- Mult 3×7, rd=5, md_ready 16 cycles after the strobe → one start_mult pulse; stall high 18 cycles; wb_valid for 1 cycle, rd=5, data=21.
- Div with b=0, md_ready+md_exception after 32 cycles, rd=8 → wb_rd=30, wb_data=5; rd 8 never written.
- Mult, md_ready never asserted, TIMEOUT_CYCLES=40 → DONE after 40 BUSY cycles; wb_rd=30, wb_data=4; IDLE the next cycle.
- Two consecutive divs (100/7→14 to rd 3, −9/2→−4 to rd 4) → two strobes, two writebacks in order; no stall gap beyond the DONE cycle.
- Mult with rd=0, result 0x12 → no wb_valid; stall releases normally.
- Reset pulled low during BUSY cycle 5 → outputs 0 asynchronously; no wb_valid. A subsequent op completes normally.

Source files
------------

// File: rtl/multdiv_issue_ctrl_if.sv
// Execute-stage / multiply-divide unit / writeback signal bundle for the mul/div issue controller.
// master = the controller, slave = the pipeline and unit surrounding it.
interface multdiv_issue_ctrl_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    // execute stage
    logic              ex_valid;
    logic              ex_is_mult;
    logic              ex_is_div;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;

    // multiply/divide unit
    logic              md_ready;
    logic              md_exception;
    logic [DATA_W-1:0] md_result;
    logic              md_start_mult;
    logic              md_start_div;
    logic [DATA_W-1:0] md_a;
    logic [DATA_W-1:0] md_b;

    // pipeline control and writeback
    logic              stall;
    logic              busy;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport master (
        input  ex_valid, ex_is_mult, ex_is_div, ex_rd, ex_a, ex_b,
        input  md_ready, md_exception, md_result,
        output md_start_mult, md_start_div, md_a, md_b,
        output stall, busy, wb_valid, wb_rd, wb_data
    );

    modport slave (
        output ex_valid, ex_is_mult, ex_is_div, ex_rd, ex_a, ex_b,
        output md_ready, md_exception, md_result,
        input  md_start_mult, md_start_div, md_a, md_b,
        input  stall, busy, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the shared multi-cycle mul/div unit: latches the op, strobes the unit,
// stalls the front end until result or timeout, then issues one writeback (result or rstatus code).
module multdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned MULT_EXC_CODE  = 4,
    parameter int unsigned DIV_EXC_CODE   = 5,
    parameter int unsigned STATUS_REG     = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    multdiv_issue_ctrl_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_mult_q, op_mult_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              start_mult_q, start_mult_d;
    logic              start_div_q, start_div_d;
    logic              busy_q, busy_d;
    logic              wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;

    logic              accept_c;
    logic              timeout_c;
    logic              exc_c;

    assign accept_c  = bus.ex_valid & (bus.ex_is_mult | bus.ex_is_div);
    assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            op_mult_q    <= 1'b0;
            rd_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            start_mult_q <= 1'b0;
            start_div_q  <= 1'b0;
            busy_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_mult_q    <= op_mult_d;
            rd_q         <= rd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            start_mult_q <= start_mult_d;
            start_div_q  <= start_div_d;
            busy_q       <= busy_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
        end
    end

    // Next-state and next-output logic; strobes and writeback default low every cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_mult_d    = op_mult_q;
        rd_d         = rd_q;
        a_d          = a_q;
        b_d          = b_q;
        start_mult_d = 1'b0;
        start_div_d  = 1'b0;
        wb_valid_d   = 1'b0;
        wb_rd_d      = '0;
        wb_data_d    = '0;
        exc_c        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_mult_d    = bus.ex_is_mult;
                    rd_d         = bus.ex_rd;
                    a_d          = bus.ex_a;
                    b_d          = bus.ex_b;
                    cnt_d        = '0;
                    start_mult_d = bus.ex_is_mult;
                    start_div_d  = bus.ex_is_div & ~bus.ex_is_mult;
                    state_d      = ST_BUSY;
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.md_ready || timeout_c) begin
                    // a real response beats a coincident timeout
                    exc_c   = bus.md_ready ? bus.md_exception : 1'b1;
                    state_d = ST_DONE;
                    if (exc_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = REG_W'(STATUS_REG);
                        wb_data_d  = op_mult_q ? DATA_W'(MULT_EXC_CODE) : DATA_W'(DIV_EXC_CODE);
                    end else begin
                        // $r0 is hardwired; suppress the write rather than the op
                        wb_valid_d = (rd_q != '0);
                        wb_rd_d    = rd_q;
                        wb_data_d  = bus.md_result;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.md_start_mult = start_mult_q;
    assign bus.md_start_div  = start_div_q;
    assign bus.md_a          = a_q;
    assign bus.md_b          = b_q;
    assign bus.busy          = busy_q;
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;

    // Front end freezes from the accept cycle through the last BUSY cycle; forced low in reset
    assign bus.stall = reset & ((state_q == ST_BUSY) | ((state_q == ST_IDLE) & accept_c));

endmodule
